// File: rtl/imem_fetch_if.sv
// Fetch-port and streaming-loader signals between the core/host side and imem_fetch.
interface imem_fetch_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  is_interrupt;
  logic                  is_stoll;
  logic                  is_jump;
  logic [31:0]           pc;
  logic [DATA_WIDTH-1:0] inst;
  logic                  inst_valid;
  logic                  fetch_fault;
  logic                  load_req;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_last;
  logic                  ld_overflow;
  logic                  loading;

  modport master (
    output is_interrupt, is_stoll, is_jump, pc, load_req, ld_valid, ld_data, ld_last,
    input  inst, inst_valid, fetch_fault, ld_ready, ld_overflow, loading
  );

  modport slave (
    input  is_interrupt, is_stoll, is_jump, pc, load_req, ld_valid, ld_data, ld_last,
    output inst, inst_valid, fetch_fault, ld_ready, ld_overflow, loading
  );
endinterface

// File: rtl/imem_fetch.sv
// Instruction memory with registered fetch port (interrupt/stall/jump/fault handling)
// and a streaming loader that writes the program image from word 0 while in LOAD.
module imem_fetch #(
  parameter int unsigned           ADDR_WIDTH    = 12,
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0] BUBBLE_INST   = DATA_WIDTH'(32'h0000_0013),
  parameter bit                    LOAD_ON_RESET = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_fetch_if.slave  bus
);

  typedef enum logic {StLoad, StRun} state_e;

  state_e                r_state, w_state_d;
  logic [ADDR_WIDTH:0]   r_ptr, w_ptr_d;
  logic                  r_ovf, w_ovf_d;
  logic [DATA_WIDTH-1:0] r_inst;
  logic                  r_valid, w_valid_d;
  logic                  r_fault, w_fault_d;
  logic                  w_we, w_rd_en, w_hold;
  logic                  w_misalign, w_oor;
  logic [ADDR_WIDTH-1:0] w_mem_addr;

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  assign w_misalign = (bus.pc[1:0] != 2'b00);
  assign w_oor      = ((bus.pc >> (ADDR_WIDTH + 2)) != 32'd0);
  // Single shared port: loader pointer in LOAD, fetch word address in RUN.
  assign w_mem_addr = (r_state == StLoad) ? r_ptr[ADDR_WIDTH-1:0] : bus.pc[ADDR_WIDTH+1:2];

  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    w_ovf_d   = r_ovf;
    w_we      = 1'b0;
    unique case (r_state)
      StLoad: begin
        if (bus.ld_valid) begin
          // MSB of the pointer set means the image already filled the memory.
          if (!r_ptr[ADDR_WIDTH]) begin
            w_we    = rst_n;
            w_ptr_d = r_ptr + {{ADDR_WIDTH{1'b0}}, 1'b1};
          end else begin
            w_ovf_d = 1'b1;
          end
          if (bus.ld_last) w_state_d = StRun;
        end
      end
      StRun: begin
        if (bus.load_req) begin
          w_state_d = StLoad;
          w_ptr_d   = '0;
          w_ovf_d   = 1'b0;
        end
      end
      default: w_state_d = StRun;
    endcase
  end

  always_comb begin
    w_rd_en   = 1'b0;
    w_hold    = 1'b0;
    w_valid_d = 1'b0;
    w_fault_d = 1'b0;
    if (r_state == StRun) begin
      if (bus.is_interrupt) begin
        w_valid_d = 1'b0;
      end else if (bus.is_stoll) begin
        w_hold    = 1'b1;
        w_valid_d = r_valid;
        w_fault_d = r_fault;
      end else if (bus.is_jump) begin
        w_valid_d = 1'b0;
      end else if (w_misalign || w_oor) begin
        w_fault_d = 1'b1;
      end else begin
        w_rd_en   = 1'b1;
        w_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= LOAD_ON_RESET ? StLoad : StRun;
      r_ptr   <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_ovf   <= w_ovf_d;
      r_valid <= w_valid_d;
      r_fault <= w_fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inst <= BUBBLE_INST;
    end else if (w_rd_en) begin
      r_inst <= r_mem[w_mem_addr];
    end else if (!w_hold) begin
      r_inst <= BUBBLE_INST;
    end
  end

  // Memory is never reset so a partial image survives a reset mid-load.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_mem_addr] <= bus.ld_data;
  end

  assign bus.inst        = r_inst;
  assign bus.inst_valid  = r_valid;
  assign bus.fetch_fault = r_fault;
  assign bus.ld_ready    = (r_state == StLoad);
  assign bus.loading     = (r_state == StLoad);
  assign bus.ld_overflow = r_ovf;

endmodule

// File: tb/tb_imem_fetch.sv
// Bench for imem_fetch: two instances (12-bit load-on-reset, 2-bit run-on-reset) checked
// every cycle against a behavioural model of memory contents and fetch rules.
module tb_imem_fetch;

  localparam logic [31:0] BUB = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v   [2];
  logic        intr_v  [2];
  logic        stall_v [2];
  logic        jump_v  [2];
  logic        lreq_v  [2];
  logic        ldv_v   [2];
  logic        last_v  [2];
  logic [31:0] pc_v    [2];
  logic [31:0] ldd_v   [2];

  imem_fetch_if #(.DATA_WIDTH(32)) ifa ();
  imem_fetch_if #(.DATA_WIDTH(32)) ifb ();

  assign ifa.is_interrupt = intr_v[0];
  assign ifa.is_stoll     = stall_v[0];
  assign ifa.is_jump      = jump_v[0];
  assign ifa.pc           = pc_v[0];
  assign ifa.load_req     = lreq_v[0];
  assign ifa.ld_valid     = ldv_v[0];
  assign ifa.ld_data      = ldd_v[0];
  assign ifa.ld_last      = last_v[0];
  assign ifb.is_interrupt = intr_v[1];
  assign ifb.is_stoll     = stall_v[1];
  assign ifb.is_jump      = jump_v[1];
  assign ifb.pc           = pc_v[1];
  assign ifb.load_req     = lreq_v[1];
  assign ifb.ld_valid     = ldv_v[1];
  assign ifb.ld_data      = ldd_v[1];
  assign ifb.ld_last      = last_v[1];

  imem_fetch #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .BUBBLE_INST(BUB), .LOAD_ON_RESET(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_v[0]), .bus(ifa)
  );

  imem_fetch #(
    .ADDR_WIDTH(2), .DATA_WIDTH(32), .BUBBLE_INST(BUB), .LOAD_ON_RESET(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_v[1]), .bus(ifb)
  );

  // Reference model state
  logic [31:0] m_mem   [2][4096];
  bit          m_wr    [2][4096];
  bit          m_load  [2];
  int          m_ptr   [2];
  bit          m_ovf   [2];
  logic [31:0] m_inst  [2];
  bit          m_known [2];
  bit          m_valid [2];
  bit          m_fault [2];

  int n_chk = 0;
  int n_err = 0;

  function automatic int depth(input int d);
    return (d == 0) ? 4096 : 4;
  endfunction

  task automatic model_edge(input int d);
    longint unsigned pcw;
    if (!rst_v[d]) begin
      m_load[d]  = (d == 0);
      m_ptr[d]   = 0;
      m_ovf[d]   = 0;
      m_inst[d]  = BUB;
      m_known[d] = 1;
      m_valid[d] = 0;
      m_fault[d] = 0;
    end else if (m_load[d]) begin
      m_inst[d]  = BUB;
      m_known[d] = 1;
      m_valid[d] = 0;
      m_fault[d] = 0;
      if (ldv_v[d]) begin
        if (m_ptr[d] < depth(d)) begin
          m_mem[d][m_ptr[d]] = ldd_v[d];
          m_wr[d][m_ptr[d]]  = 1;
          m_ptr[d]++;
        end else begin
          m_ovf[d] = 1;
        end
        if (last_v[d]) m_load[d] = 0;
      end
    end else begin
      pcw = longint'(pc_v[d]);
      if (intr_v[d] || (!stall_v[d] && jump_v[d])) begin
        m_inst[d] = BUB; m_known[d] = 1; m_valid[d] = 0; m_fault[d] = 0;
      end else if (stall_v[d]) begin
        // outputs hold
      end else if ((pcw % 4) != 0 || pcw >= longint'(depth(d)) * 4) begin
        m_inst[d] = BUB; m_known[d] = 1; m_valid[d] = 0; m_fault[d] = 1;
      end else begin
        m_inst[d]  = m_mem[d][pcw / 4];
        m_known[d] = m_wr[d][pcw / 4];
        m_valid[d] = 1;
        m_fault[d] = 0;
      end
      if (lreq_v[d]) begin
        m_load[d] = 1; m_ptr[d] = 0; m_ovf[d] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input int d, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic check_all(input int d);
    logic [31:0] inst;
    logic v, f, ld, rdy, ovf;
    if (d == 0) begin
      inst = ifa.inst; v = ifa.inst_valid; f = ifa.fetch_fault;
      ld = ifa.loading; rdy = ifa.ld_ready; ovf = ifa.ld_overflow;
    end else begin
      inst = ifb.inst; v = ifb.inst_valid; f = ifb.fetch_fault;
      ld = ifb.loading; rdy = ifb.ld_ready; ovf = ifb.ld_overflow;
    end
    if (m_known[d]) chk("inst", d, inst, m_inst[d]);
    chk("inst_valid",  d, 32'(v),   32'(m_valid[d]));
    chk("fetch_fault", d, 32'(f),   32'(m_fault[d]));
    chk("loading",     d, 32'(ld),  32'(m_load[d]));
    chk("ld_ready",    d, 32'(rdy), 32'(m_load[d]));
    chk("ld_overflow", d, 32'(ovf), 32'(m_ovf[d]));
  endtask

  task automatic cyc();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    check_all(0);
    check_all(1);
  endtask

  task automatic idle(input int d);
    rst_v[d] = 1; intr_v[d] = 0; stall_v[d] = 0; jump_v[d] = 0; lreq_v[d] = 0;
    ldv_v[d] = 0; last_v[d] = 0; pc_v[d] = 0; ldd_v[d] = $urandom;
  endtask

  task automatic stream(input int d, input logic [31:0] w, input bit last);
    int gap;
    gap = $urandom_range(0, 2);
    ldv_v[d] = 0;
    repeat (gap) begin
      ldd_v[d] = $urandom;
      cyc();
    end
    ldv_v[d] = 1; ldd_v[d] = w; last_v[d] = last;
    cyc();
    ldv_v[d] = 0; last_v[d] = 0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      idle(d);
      rst_v[d] = 0;
      m_inst[d] = BUB; m_known[d] = 0;
    end
    cyc();
    cyc();
    rst_v[0] = 1;
    rst_v[1] = 1;

    // Boot image into A, then fetch it back
    for (int i = 0; i < 4; i++) stream(0, 32'h1111_1111 * (i + 1), i == 3);
    for (int i = 0; i < 4; i++) begin
      pc_v[0] = 32'(i * 4);
      cyc();
    end

    // Priority: interrupt over stall over jump, then jump alone, then normal
    intr_v[0] = 1; stall_v[0] = 1; jump_v[0] = 1; pc_v[0] = 32'h8;
    cyc();
    intr_v[0] = 0; stall_v[0] = 0;
    cyc();
    jump_v[0] = 0; pc_v[0] = 32'h4;
    cyc();

    // Misaligned and out-of-range fetches
    pc_v[0] = 32'h6;
    cyc();
    pc_v[0] = 32'h4000;
    cyc();
    pc_v[0] = 32'h0;
    cyc();

    // Reload A; fetch on the load_req cycle still completes
    lreq_v[0] = 1; pc_v[0] = 32'h8;
    cyc();
    lreq_v[0] = 0;
    for (int i = 0; i < 6; i++) stream(0, $urandom, 1'b0);
    rst_v[0] = 0; ldv_v[0] = 1; ldd_v[0] = $urandom;
    cyc();
    rst_v[0] = 1; ldv_v[0] = 0;
    stream(0, $urandom, 1'b0);
    stream(0, $urandom, 1'b1);
    for (int i = 0; i < 6; i++) begin
      pc_v[0] = 32'(i * 4);
      cyc();
    end

    // Stall holds the pc=0x8 word while pc moves to 0x10
    pc_v[0] = 32'h8;
    cyc();
    stall_v[0] = 1; pc_v[0] = 32'h10;
    repeat (3) cyc();
    stall_v[0] = 0;
    cyc();

    // Small memory: overflow on 5th word, fetch last stored word
    lreq_v[1] = 1;
    cyc();
    lreq_v[1] = 0;
    for (int i = 0; i < 5; i++) stream(1, $urandom, i == 4);
    pc_v[1] = 32'hC;
    cyc();
    pc_v[1] = 32'h4;
    cyc();

    // Randomised fetch traffic on both instances
    for (int n = 0; n < 80; n++) begin
      for (int d = 0; d < 2; d++) begin
        pc_v[d]    = 32'($urandom_range(0, (d == 0) ? 5 : 3) * 4);
        if ($urandom_range(0, 9) == 0) pc_v[d] = pc_v[d] + 32'($urandom_range(1, 3));
        if ($urandom_range(0, 9) == 0) pc_v[d] = pc_v[d] | ((d == 0) ? 32'h4000 : 32'h10);
        intr_v[d]  = ($urandom_range(0, 7) == 0);
        stall_v[d] = ($urandom_range(0, 4) == 0);
        jump_v[d]  = ($urandom_range(0, 7) == 0);
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
